// File: rtl/tetris_pkg.sv
// Shared board geometry, line-clear FSM encoding and the per-clear score table.
package tetris_pkg;
    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int ROW_AW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_READ,
        S_CHECK,
        S_FILL,
        S_DONE
    } lce_state_e;

    // Points awarded for a single operation that cleared cnt rows.
    function automatic logic [3:0] score_inc(input int unsigned cnt);
        if (cnt >= 4)      return 4'd8;
        else if (cnt == 3) return 4'd5;
        else if (cnt == 2) return 4'd3;
        else if (cnt == 1) return 4'd1;
        else               return 4'd0;
    endfunction
endpackage

// File: rtl/line_clear_engine_if.sv
// Board RAM port bundle: engine drives addresses/writes, RAM returns read data.
interface line_clear_engine_if
    import tetris_pkg::*;
#(
    parameter int AW = tetris_pkg::ROW_AW,
    parameter int DW = tetris_pkg::COLS
);
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/lce_score_acc.sv
// Saturating 16-bit score accumulator, loaded once per completed line-clear op.
module lce_score_acc
    import tetris_pkg::*;
#(
    parameter int CW = tetris_pkg::ROW_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] cnt,
    output logic [15:0]   score
);
    logic [15:0] score_q;
    logic [16:0] sum;

    assign sum = {1'b0, score_q} + {13'b0, score_inc(32'(cnt))};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    score_q <= '0;
        else if (load) score_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end

    assign score = score_q;
endmodule

// File: rtl/line_clear_engine.sv
// Drops full board rows bottom-to-top, compacts the rest and zero-fills the top.
// Score accumulator is built only when LINE_CLEAR_SCORE_EN is defined.
module line_clear_engine #(
    parameter int ROWS   = tetris_pkg::ROWS,
    parameter int COLS   = tetris_pkg::COLS,
    parameter int ROW_AW = tetris_pkg::ROW_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                remove_1,
    input  logic                remove_2,
    output logic                remove_2_finish,
    output logic                busy,
    line_clear_engine_if.master ram,
    output logic [2:0]          lines_cleared,
    output logic [15:0]         score
);
    import tetris_pkg::*;

    localparam logic [ROW_AW-1:0] TOP_ROW = ROW_AW'(ROWS - 1);

    lce_state_e        state;
    logic [ROW_AW-1:0] src, dst, cnt, cnt_nxt;
    logic              row_full;

    assign row_full = &ram.rd_data;
    // The row just checked must count before deciding whether any fill is needed.
    assign cnt_nxt  = cnt + ROW_AW'(row_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            src             <= TOP_ROW;
            dst             <= TOP_ROW;
            cnt             <= '0;
            busy            <= 1'b0;
            remove_2_finish <= 1'b0;
            lines_cleared   <= '0;
        end else begin
            remove_2_finish <= 1'b0;
            case (state)
                S_IDLE: if (remove_1) begin
                    state <= S_ARMED;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    src   <= TOP_ROW;
                    dst   <= TOP_ROW;
                end
                S_ARMED: if (remove_2) state <= S_READ;
                S_READ: begin
                    if (!remove_2) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt <= cnt_nxt;
                    if (!row_full) dst <= dst - 1'b1;
                    if (!remove_2) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (src == '0) begin
                        if (cnt_nxt == '0) begin
                            state           <= S_DONE;
                            remove_2_finish <= 1'b1;
                        end else begin
                            state <= S_FILL;
                        end
                    end else begin
                        src   <= src - 1'b1;
                        state <= S_READ;
                    end
                end
                S_FILL: begin
                    if (!remove_2) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (dst == '0) begin
                        state           <= S_DONE;
                        remove_2_finish <= 1'b1;
                    end else begin
                        dst <= dst - 1'b1;
                    end
                end
                S_DONE: begin
                    lines_cleared <= (cnt > ROW_AW'(7)) ? 3'd7 : cnt[2:0];
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Kept rows move down only when a gap exists; FILL blanks the vacated top rows.
    always_comb begin
        ram.rd_addr = '0;
        ram.wr_en   = 1'b0;
        ram.wr_addr = '0;
        ram.wr_data = '0;
        if (state == S_READ || state == S_CHECK) ram.rd_addr = src;
        if (state == S_CHECK && !row_full && src != dst) begin
            ram.wr_en   = 1'b1;
            ram.wr_addr = dst;
            ram.wr_data = ram.rd_data;
        end
        if (state == S_FILL) begin
            ram.wr_en   = 1'b1;
            ram.wr_addr = dst;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    lce_score_acc #(.CW(ROW_AW)) u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == S_DONE),
        .cnt   (cnt),
        .score (score)
    );
`else
    assign score = '0;
`endif
endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: stimulus queues expected writes/finishes, monitor checks.
module tb_line_clear_engine;
    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef struct { logic [4:0] a; logic [COLS-1:0] d; } wr_t;
    typedef struct { int lat; logic [2:0] lines; logic [15:0] score; } fin_t;

    logic clk, rst_n, remove_1, remove_2, remove_2_finish, busy;
    logic [2:0]  lines_cleared;
    logic [15:0] score;

    line_clear_engine_if #(.AW(5), .DW(COLS)) ram_if ();

    line_clear_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .remove_1        (remove_1),
        .remove_2        (remove_2),
        .remove_2_finish (remove_2_finish),
        .busy            (busy),
        .ram             (ram_if),
        .lines_cleared   (lines_cleared),
        .score           (score)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0, t0 = 0;
    wr_t  wq[$];
    fin_t fq[$];
    fin_t pf;
    wr_t  w;
    bit   pend = 0;
    logic [2:0]      exp_lines;
    logic [15:0]     exp_score;
    logic [COLS-1:0] mem [32];
    logic [COLS-1:0] img [ROWS];
    logic [COLS-1:0] exp_img [ROWS];
    logic            ld_go;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Board RAM model: 1-cycle read latency, bulk preload when ld_go.
    always @(posedge clk) begin
        if (ld_go) for (int i = 0; i < ROWS; i++) mem[i] <= img[i];
        else if (ram_if.wr_en) mem[ram_if.wr_addr] <= ram_if.wr_data;
        ram_if.rd_data <= mem[ram_if.rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (ram_if.wr_en) begin
            if (wq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         ram_if.wr_addr, ram_if.wr_data);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(ram_if.wr_addr), 32'(w.a));
                chk("wr_data", 32'(ram_if.wr_data), 32'(w.d));
            end
        end
        if (remove_2_finish) begin
            if (fq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_finish: got pulse expected none");
            end else begin
                pf = fq.pop_front();
                chk("finish_latency", 32'(cyc - t0 + 1), 32'(pf.lat));
                pend = 1;
            end
        end else if (pend) begin
            chk("lines_cleared", 32'(lines_cleared), 32'(pf.lines));
            chk("score", 32'(score), 32'(pf.score));
            pend = 0;
        end
    end

    function automatic logic [15:0] sc_next(input logic [15:0] s, input int cnt);
`ifdef LINE_CLEAR_SCORE_EN
        int inc, sum;
        inc = (cnt >= 4) ? 8 : (cnt == 3) ? 5 : (cnt == 2) ? 3 : (cnt == 1) ? 1 : 0;
        sum = int'(s) + inc;
        return (sum > 65535) ? 16'hFFFF : sum[15:0];
`else
        return 16'h0000 & s;
`endif
    endfunction

    task automatic push_wr(input int a, input int d);
        wr_t x;
        x.a = 5'(a);
        x.d = COLS'(d);
        wq.push_back(x);
    endtask

    task automatic push_fin(input int lat, input int cnt);
        fin_t x;
        exp_lines = (cnt > 7) ? 3'd7 : 3'(cnt);
        exp_score = sc_next(exp_score, cnt);
        x.lat = lat; x.lines = exp_lines; x.score = exp_score;
        fq.push_back(x);
    endtask

    task automatic load_board();
        @(negedge clk); ld_go = 1;
        @(negedge clk); ld_go = 0;
    endtask

    task automatic start_op();
        @(negedge clk); remove_1 = 1;
        @(negedge clk); remove_1 = 0; remove_2 = 1; t0 = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((fq.size() != 0 || pend) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL finish_timeout: got no finish expected one within 300 cycles");
        end
    endtask

    task automatic chk_ram(input string nm);
        int bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (mem[r] !== exp_img[r]) begin
                if (bad == 0) $display("FAIL %s row %0d: got %0h expected %0h", nm, r, mem[r], exp_img[r]);
                bad++;
            end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic end_op(input string nm);
        @(negedge clk); remove_2 = 0;
        @(negedge clk);
        chk("busy_after_op", 32'(busy), 0);
        chk("writes_left", 32'(wq.size()), 0);
        chk_ram(nm);
    endtask

    // Rows 19,17,15,10 full, others hold their own index.
    task automatic setup_t3();
        for (int r = 0; r < ROWS; r++) img[r] = COLS'(r);
        img[19] = '1; img[17] = '1; img[15] = '1; img[10] = '1;
        for (int r = 0; r < ROWS; r++) exp_img[r] = '0;
        exp_img[19] = 18; exp_img[18] = 16; exp_img[17] = 14;
        exp_img[16] = 13; exp_img[15] = 12; exp_img[14] = 11;
        for (int r = 13; r >= 4; r--) exp_img[r] = COLS'(r - 4);
        load_board();
        push_wr(19, 18); push_wr(18, 16); push_wr(17, 14);
        push_wr(16, 13); push_wr(15, 12); push_wr(14, 11);
        for (int s = 9; s >= 0; s--) push_wr(s + 4, s);
        for (int r = 3; r >= 0; r--) push_wr(r, 0);
        push_fin(46, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary expected finish before timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 0; remove_1 = 0; remove_2 = 0; ld_go = 0;
        exp_lines = 0; exp_score = 0;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_finish", 32'(remove_2_finish), 0);
        chk("rst_lines", 32'(lines_cleared), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_wr_en", 32'(ram_if.wr_en), 0);
        chk("rst_rd_addr", 32'(ram_if.rd_addr), 0);
        rst_n = 1;

        // remove_2 alone must not start anything
        remove_2 = 1;
        repeat (4) @(negedge clk);
        chk("r2_only_busy", 32'(busy), 0);
        remove_2 = 0;

        // T1: empty board
        for (int r = 0; r < ROWS; r++) begin img[r] = '0; exp_img[r] = '0; end
        load_board();
        push_fin(42, 0);
        start_op(); wait_done(); end_op("t1_ram");

        // T2: bottom row full, row 18 = 1
        img[19] = '1; img[18] = 10'h001;
        exp_img[19] = 10'h001;
        load_board();
        push_wr(19, 1);
        for (int s = 17; s >= 0; s--) push_wr(s + 1, 0);
        push_wr(0, 0);
        push_fin(43, 1);
        start_op(); wait_done(); end_op("t2_ram");

        // T3: four scattered full rows, stray remove_1 mid-op
        setup_t3();
        start_op();
        repeat (5) @(negedge clk);
        remove_1 = 1; @(negedge clk); remove_1 = 0;
        wait_done(); end_op("t3_ram");

        // T4: drop remove_2 in CHECK of row 12
        for (int r = 0; r < ROWS; r++) begin img[r] = COLS'(r); exp_img[r] = COLS'(r); end
        img[19] = '1;
        for (int r = 13; r <= 19; r++) exp_img[r] = COLS'(r - 1);
        load_board();
        for (int s = 18; s >= 12; s--) push_wr(s + 1, s);
        start_op();
        repeat (16) @(negedge clk);
        remove_2 = 0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("abort_lines", 32'(lines_cleared), 32'(exp_lines));
        chk("abort_score", 32'(score), 32'(exp_score));
        chk("abort_writes_left", 32'(wq.size()), 0);
        chk_ram("t4_ram");

        // T5: reset during FILL, then a clean pass
        for (int r = 0; r < ROWS; r++) begin img[r] = '0; exp_img[r] = '0; end
        img[19] = '1; img[18] = '1;
        load_board();
        for (int s = 17; s >= 0; s--) push_wr(s + 2, 0);
        push_wr(1, 0);
        start_op();
        repeat (41) @(negedge clk);
        #1 rst_n = 0; remove_2 = 0;
        #1;
        exp_lines = 0; exp_score = 0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_en", 32'(ram_if.wr_en), 0);
        chk("midrst_wr_addr", 32'(ram_if.wr_addr), 0);
        chk("midrst_rd_addr", 32'(ram_if.rd_addr), 0);
        chk("midrst_lines", 32'(lines_cleared), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_writes_left", 32'(wq.size()), 0);
        @(negedge clk); rst_n = 1;
        chk_ram("t5_partial_ram");
        setup_t3();
        start_op(); wait_done(); end_op("t5_clean_ram");

        // T6: score saturation
`ifdef LINE_CLEAR_SCORE_EN
        @(negedge clk); force dut.u_score.score_q = 16'hFFFE;
        @(negedge clk); release dut.u_score.score_q;
        exp_score = 16'hFFFE;
`endif
        setup_t3();
        start_op(); wait_done(); end_op("t6_ram");
        chk("final_score", 32'(score), 32'(exp_score));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
